// File: rtl/lobinho_pkg.sv
// Shared definitions for the PoliLobinho datapath: player count, widths,
// special codes, FSM encoding of the vote tally stage and small helpers
// that index player masks safely with an arbitrary 3-bit code.
package lobinho_pkg;

    localparam int N_JOGADORES = 5;
    localparam int W_ID        = 3;
    localparam int W_CNT       = 3;

    // Candidate code meaning "skip / nobody eliminated"
    localparam logic [W_ID-1:0] PULAR = 3'd5;

    // Player roles used elsewhere in the game datapath
    localparam logic [1:0] CLASSE_ALDEAO = 2'd0;
    localparam logic [1:0] CLASSE_LOBO   = 2'd1;
    localparam logic [1:0] CLASSE_MEDICO = 2'd2;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        COLETANDO = 2'd1,
        APURANDO  = 2'd2,
        RESULTADO = 2'd3
    } estado_t;

    // Bit of a per-player mask; codes outside 0..N_JOGADORES-1 read as 0
    function automatic logic bit_jogador(input logic [N_JOGADORES-1:0] vetor,
                                         input logic [W_ID-1:0]        indice);
        logic v_bit;
        v_bit = 1'b0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            if (indice == W_ID'(i)) begin
                v_bit = vetor[i];
            end
        end
        return v_bit;
    endfunction

    // A code names a living player only if it is in range and not marked dead
    function automatic logic jogador_vivo(input logic [N_JOGADORES-1:0] mortes,
                                          input logic [W_ID-1:0]        indice);
        return (indice < W_ID'(N_JOGADORES)) && !bit_jogador(mortes, indice);
    endfunction

    // One-hot mask with the bit of the given player set
    function automatic logic [N_JOGADORES-1:0] mascara_jogador(input logic [W_ID-1:0] indice);
        logic [N_JOGADORES-1:0] v_mascara;
        v_mascara = '0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            if (indice == W_ID'(i)) begin
                v_mascara[i] = 1'b1;
            end
        end
        return v_mascara;
    endfunction

    // Number of living players in a dead-player mask
    function automatic logic [W_ID-1:0] contar_vivos(input logic [N_JOGADORES-1:0] mortes);
        logic [W_ID-1:0] v_total;
        v_total = '0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            if (!mortes[i]) begin
                v_total = v_total + W_ID'(1);
            end
        end
        return v_total;
    endfunction

endpackage

// File: rtl/scan_maximo.sv
// Sequential argmax / tie tracker. i_start clears the running maximum and
// rewinds the index; each i_step consumes the value for o_indice and moves
// on. o_done is high during the step that consumes the last candidate
// (the skip code), so the caller can leave its scan state on that edge.
module scan_maximo
    import lobinho_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_step,
    input  logic [W_CNT-1:0]  i_valor,
    output logic [W_ID-1:0]   o_indice,
    output logic              o_done,
    output logic [W_CNT-1:0]  o_max,
    output logic [W_ID-1:0]   o_arg,
    output logic              o_empate
);

    logic [W_ID-1:0]  r_indice;
    logic [W_CNT-1:0] r_max;
    logic [W_ID-1:0]  r_arg;
    logic             r_empate;

    // Running maximum: a strictly larger tally takes over and clears the tie,
    // an equal non-zero tally marks a tie with the current leader
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_indice <= '0;
            r_max    <= '0;
            r_arg    <= '0;
            r_empate <= 1'b0;
        end else if (i_start) begin
            r_indice <= '0;
            r_max    <= '0;
            r_arg    <= '0;
            r_empate <= 1'b0;
        end else if (i_step) begin
            if (i_valor > r_max) begin
                r_max    <= i_valor;
                r_arg    <= r_indice;
                r_empate <= 1'b0;
            end else if ((i_valor == r_max) && (r_max != '0)) begin
                r_empate <= 1'b1;
            end
            if (r_indice != PULAR) begin
                r_indice <= r_indice + W_ID'(1);
            end
        end
    end

    assign o_indice = r_indice;
    assign o_done   = i_step && (r_indice == PULAR);
    assign o_max    = r_max;
    assign o_arg    = r_arg;
    assign o_empate = r_empate;

endmodule

// File: rtl/apuracao_votos.sv
// Day-phase vote tally for PoliLobinho. Collects one vote per living
// player, rejects invalid ones, then scans the tallies (players 0..4 and
// the skip code 5) to choose who is eliminated.
// Optional build macro MAIORIA_ABSOLUTA_EN: a non-skip winner is only
// eliminated with more than half of the living players' votes.
module apuracao_votos
    import lobinho_pkg::*;
(
    input  logic                   clock,
    input  logic                   rst_global_n,
    input  logic                   iniciar,
    input  logic                   fechar,
    input  logic                   voto_valido,
    input  logic [W_ID-1:0]        jogador_votante,
    input  logic [W_ID-1:0]        jogador_escolhido,
    input  logic [N_JOGADORES-1:0] mortes,
    output logic                   ocupado,
    output logic                   voto_aceito,
    output logic                   voto_rejeitado,
    output logic                   resultado_valido,
    output logic [W_ID-1:0]        eliminado,
    output logic                   empate
);

    estado_t                r_estado;
    estado_t                w_proximo;
    logic [W_CNT-1:0]       r_tally [0:N_JOGADORES];
    logic [N_JOGADORES-1:0] r_votou;
    logic                   r_aceito;
    logic                   r_rejeitado;
    logic [W_ID-1:0]        r_eliminado;
    logic                   r_empate;

    logic                   w_votante_ok;
    logic                   w_escolhido_ok;
    logic                   w_fechar;
    logic                   w_limpar;
    logic                   w_aceitar;
    logic                   w_scan_start;
    logic                   w_scan_step;
    logic                   w_scan_done;
    logic [W_ID-1:0]        w_scan_indice;
    logic [W_CNT-1:0]       w_scan_valor;
    logic [W_CNT-1:0]       w_scan_max;
    logic [W_ID-1:0]        w_scan_arg;
    logic                   w_scan_empate;
    logic [W_ID-1:0]        w_res_eliminado;
    logic                   w_res_empate;

`ifdef MAIORIA_ABSOLUTA_EN
    logic [W_ID-1:0]        r_vivos;
`endif

    // A voter must be alive and not have voted yet; a candidate must be the
    // skip code or a living player. mortes is live, so a death mid-round
    // only affects votes presented after it.
    assign w_votante_ok   = jogador_vivo(mortes, jogador_votante)
                            && !bit_jogador(r_votou, jogador_votante);
    assign w_escolhido_ok = (jogador_escolhido == PULAR)
                            || jogador_vivo(mortes, jogador_escolhido);

    // The round ends on timeout or once every living player has a vote on
    // record; the mask is registered, so this fires the cycle after the last vote
    assign w_fechar = fechar || (r_votou == ~mortes);

    // FSM state register
    always_ff @(posedge clock or negedge rst_global_n) begin
        if (!rst_global_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next state plus the control strobes for the tally and the scanner
    always_comb begin
        w_proximo    = r_estado;
        w_limpar     = 1'b0;
        w_aceitar    = 1'b0;
        w_scan_start = 1'b0;
        w_scan_step  = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (iniciar) begin
                    w_limpar  = 1'b1;
                    w_proximo = COLETANDO;
                end
            end
            COLETANDO: begin
                if (iniciar) begin
                    w_limpar = 1'b1;
                end else begin
                    w_aceitar = voto_valido && w_votante_ok && w_escolhido_ok;
                    if (w_fechar) begin
                        w_scan_start = 1'b1;
                        w_proximo    = APURANDO;
                    end
                end
            end
            APURANDO: begin
                w_scan_step = 1'b1;
                if (w_scan_done) begin
                    w_proximo = RESULTADO;
                end
            end
            RESULTADO: begin
                w_proximo = OCIOSO;
            end
            default: begin
                w_proximo = OCIOSO;
            end
        endcase
    end

    // Tallies and voted-mask: cleared when a round opens, bumped per accepted vote
    always_ff @(posedge clock or negedge rst_global_n) begin
        if (!rst_global_n) begin
            for (int i = 0; i <= N_JOGADORES; i++) begin
                r_tally[i] <= '0;
            end
            r_votou <= '0;
        end else if (w_limpar) begin
            for (int i = 0; i <= N_JOGADORES; i++) begin
                r_tally[i] <= '0;
            end
            r_votou <= '0;
        end else if (w_aceitar) begin
            for (int i = 0; i <= N_JOGADORES; i++) begin
                if ((jogador_escolhido == W_ID'(i)) && (r_tally[i] < W_CNT'(N_JOGADORES))) begin
                    r_tally[i] <= r_tally[i] + W_CNT'(1);
                end
            end
            r_votou <= r_votou | mascara_jogador(jogador_votante);
        end
    end

    // Accept/reject pulses appear the cycle after the vote is presented
    always_ff @(posedge clock or negedge rst_global_n) begin
        if (!rst_global_n) begin
            r_aceito    <= 1'b0;
            r_rejeitado <= 1'b0;
        end else begin
            r_aceito    <= w_aceitar;
            r_rejeitado <= voto_valido && !w_aceitar;
        end
    end

    // Feed the scanner the tally of the candidate it is currently looking at
    always_comb begin
        w_scan_valor = '0;
        for (int i = 0; i <= N_JOGADORES; i++) begin
            if (w_scan_indice == W_ID'(i)) begin
                w_scan_valor = r_tally[i];
            end
        end
    end

    scan_maximo u_scan_maximo (
        .i_clock  (clock),
        .i_rst_n  (rst_global_n),
        .i_start  (w_scan_start),
        .i_step   (w_scan_step),
        .i_valor  (w_scan_valor),
        .o_indice (w_scan_indice),
        .o_done   (w_scan_done),
        .o_max    (w_scan_max),
        .o_arg    (w_scan_arg),
        .o_empate (w_scan_empate)
    );

`ifdef MAIORIA_ABSOLUTA_EN
    // Living-player count frozen at the moment the scan starts
    always_ff @(posedge clock or negedge rst_global_n) begin
        if (!rst_global_n) begin
            r_vivos <= '0;
        end else if (w_scan_start) begin
            r_vivos <= contar_vivos(mortes);
        end
    end
`endif

    // Final decision: a tie or an empty ballot eliminates nobody
    always_comb begin
        w_res_eliminado = w_scan_arg;
        w_res_empate    = w_scan_empate;
        if (w_scan_empate || (w_scan_max == '0)) begin
            w_res_eliminado = PULAR;
        end
`ifdef MAIORIA_ABSOLUTA_EN
        else if ((w_scan_arg != PULAR) && !({w_scan_max, 1'b0} > {1'b0, r_vivos})) begin
            w_res_eliminado = PULAR;
        end
`endif
    end

    // Hold the last published result while idle or collecting the next round
    always_ff @(posedge clock or negedge rst_global_n) begin
        if (!rst_global_n) begin
            r_eliminado <= PULAR;
            r_empate    <= 1'b0;
        end else if (r_estado == RESULTADO) begin
            r_eliminado <= w_res_eliminado;
            r_empate    <= w_res_empate;
        end
    end

    assign ocupado          = (r_estado == COLETANDO) || (r_estado == APURANDO);
    assign voto_aceito      = r_aceito;
    assign voto_rejeitado   = r_rejeitado;
    assign resultado_valido = (r_estado == RESULTADO);
    assign eliminado        = resultado_valido ? w_res_eliminado : r_eliminado;
    assign empate           = resultado_valido ? w_res_empate    : r_empate;

endmodule

// File: tb/tb_apuracao_votos.sv
// Scoreboard bench for apuracao_votos. Stimulus pushes the expected
// accept/reject pulse and round result (with the cycle it must appear in)
// into queues; a negedge monitor pops and compares whenever the DUT pulses.
module tb_apuracao_votos;

    logic       clock = 1'b0;
    logic       rst_global_n;
    logic       iniciar;
    logic       fechar;
    logic       voto_valido;
    logic [2:0] jogador_votante;
    logic [2:0] jogador_escolhido;
    logic [4:0] mortes;
    logic       ocupado;
    logic       voto_aceito;
    logic       voto_rejeitado;
    logic       resultado_valido;
    logic [2:0] eliminado;
    logic       empate;

    typedef struct {
        logic aceito;
        int   ciclo;
    } votoEsp_t;

    typedef struct {
        logic [2:0] elim;
        logic       empate;
        int         ciclo;
    } resEsp_t;

    votoEsp_t   filaVotos[$];
    resEsp_t    filaRes[$];
    int         tally[6];
    logic [4:0] votou;
    bit         emColeta;
    int         cyc = 0;
    int         nAssert = 0;
    int         nFail = 0;

    apuracao_votos dut (
        .clock             (clock),
        .rst_global_n      (rst_global_n),
        .iniciar           (iniciar),
        .fechar            (fechar),
        .voto_valido       (voto_valido),
        .jogador_votante   (jogador_votante),
        .jogador_escolhido (jogador_escolhido),
        .mortes            (mortes),
        .ocupado           (ocupado),
        .voto_aceito       (voto_aceito),
        .voto_rejeitado    (voto_rejeitado),
        .resultado_valido  (resultado_valido),
        .eliminado         (eliminado),
        .empate            (empate)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        nAssert++;
        if (atual !== esperado) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit morto(input int i);
        if (i < 0 || i > 4) return 1'b1;
        return mortes[i];
    endfunction

    // Reference outcome from the spec rules: unique non-zero maximum wins,
    // shared maximum is a tie, nothing counted eliminates nobody
    function automatic void calcularResultado(output logic [2:0] e, output logic t);
        int mx, n, arg;
        mx = 0; n = 0; arg = 5;
        for (int i = 0; i < 6; i++) if (tally[i] > mx) mx = tally[i];
        for (int i = 0; i < 6; i++) if (tally[i] == mx) begin n++; arg = i; end
        if (mx == 0) begin
            e = 3'd5; t = 1'b0;
        end else if (n > 1) begin
            e = 3'd5; t = 1'b1;
        end else begin
            e = 3'(arg); t = 1'b0;
`ifdef MAIORIA_ABSOLUTA_EN
            begin
                int vivos;
                vivos = 0;
                for (int i = 0; i < 5; i++) if (!mortes[i]) vivos++;
                if (arg != 5 && 2 * mx <= vivos) e = 3'd5;
            end
`endif
        end
    endfunction

    task automatic agendarResultado(input int ciclo);
        resEsp_t r;
        calcularResultado(r.elim, r.empate);
        r.ciclo = ciclo;
        filaRes.push_back(r);
        emColeta = 1'b0;
    endtask

    task automatic iniciarRodada(input logic [4:0] m);
        mortes  = m;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        for (int i = 0; i < 6; i++) tally[i] = 0;
        votou    = '0;
        emColeta = 1'b1;
    endtask

    // Present one vote (optionally together with fechar) and predict its fate
    task automatic applyStimulus(input int v, input int e, input bit comFechar);
        votoEsp_t x;
        bit ok;
        int k;
        k  = cyc;
        ok = emColeta && (v < 5) && !morto(v) && (votou[v] == 1'b0)
             && (e == 5 || (e < 5 && !morto(e)));
        x.aceito = ok;
        x.ciclo  = k + 1;
        filaVotos.push_back(x);
        if (ok) begin
            tally[e]++;
            votou[v] = 1'b1;
        end
        voto_valido       = 1'b1;
        jogador_votante   = 3'(v);
        jogador_escolhido = 3'(e);
        fechar            = comFechar;
        if (emColeta && comFechar) agendarResultado(k + 7);
        else if (emColeta && votou == ~mortes) agendarResultado(k + 8);
        tick();
        voto_valido = 1'b0;
        fechar      = 1'b0;
    endtask

    task automatic fecharRodada();
        int k;
        k = cyc;
        fechar = 1'b1;
        if (emColeta) agendarResultado(k + 7);
        tick();
        fechar = 1'b0;
    endtask

    task automatic esperarResultado();
        for (int i = 0; i < 40 && filaRes.size() != 0; i++) tick();
        checkOutput("resultado_pendente", filaRes.size(), 0);
        tick();
    endtask

    // Monitor: every pulse from the DUT must match the head of its queue
    always @(negedge clock) begin
        votoEsp_t x;
        resEsp_t  r;
        if (rst_global_n === 1'b1) begin
            if (voto_aceito === 1'b1 || voto_rejeitado === 1'b1) begin
                if (filaVotos.size() == 0) begin
                    nAssert++;
                    nFail++;
                    $display("[TB] FAIL voto_inesperado: aceito=%b rejeitado=%b expected no pulse (cycle %0d)",
                             voto_aceito, voto_rejeitado, cyc);
                end else begin
                    x = filaVotos.pop_front();
                    checkOutput("voto_aceito", voto_aceito, x.aceito);
                    checkOutput("voto_rejeitado", voto_rejeitado, !x.aceito);
                    checkOutput("voto_ciclo", cyc, x.ciclo);
                end
            end
            if (resultado_valido === 1'b1) begin
                if (filaRes.size() == 0) begin
                    nAssert++;
                    nFail++;
                    $display("[TB] FAIL resultado_inesperado: eliminado=%0d expected no pulse (cycle %0d)",
                             eliminado, cyc);
                end else begin
                    r = filaRes.pop_front();
                    checkOutput("eliminado", eliminado, r.elim);
                    checkOutput("empate", empate, r.empate);
                    checkOutput("resultado_ciclo", cyc, r.ciclo);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_global_n      = 1'b0;
        iniciar           = 1'b0;
        fechar            = 1'b0;
        voto_valido       = 1'b0;
        jogador_votante   = '0;
        jogador_escolhido = '0;
        mortes            = '0;
        votou             = '0;
        emColeta          = 1'b0;
        #12;
        checkOutput("reset_eliminado", eliminado, 5);
        checkOutput("reset_empate", empate, 0);
        checkOutput("reset_ocupado", ocupado, 0);
        checkOutput("reset_resultado", resultado_valido, 0);
        checkOutput("reset_aceito", voto_aceito, 0);
        checkOutput("reset_rejeitado", voto_rejeitado, 0);
        tick();
        rst_global_n = 1'b1;
        tick();

        $display("[TB] plurality round, automatic close");
        iniciarRodada(5'b00000);
        checkOutput("ocupado_coleta", ocupado, 1);
        applyStimulus(0, 3, 0);
        applyStimulus(1, 3, 0);
        applyStimulus(2, 3, 0);
        applyStimulus(3, 4, 0);
        applyStimulus(4, 5, 0);
        esperarResultado();
        checkOutput("eliminado_retido", eliminado, 3);
        checkOutput("ocupado_ocioso", ocupado, 0);

        $display("[TB] tie round");
        iniciarRodada(5'b00001);
        applyStimulus(1, 3, 0);
        applyStimulus(2, 3, 0);
        applyStimulus(3, 4, 0);
        applyStimulus(4, 4, 0);
        esperarResultado();
        checkOutput("empate_retido", empate, 1);

        $display("[TB] async reset during scan");
        iniciarRodada(5'b00000);
        applyStimulus(0, 1, 0);
        applyStimulus(1, 2, 0);
        fecharRodada();
        tick();
        tick();
        checkOutput("ocupado_apurando", ocupado, 1);
        #2;
        rst_global_n = 1'b0;
        #1;
        checkOutput("rst_ocupado", ocupado, 0);
        checkOutput("rst_eliminado", eliminado, 5);
        checkOutput("rst_empate", empate, 0);
        checkOutput("rst_resultado", resultado_valido, 0);
        filaRes.delete();
        emColeta = 1'b0;
        tick();
        rst_global_n = 1'b1;
        tick();
        iniciarRodada(5'b00000);
        applyStimulus(2, 4, 0);
        fecharRodada();
        esperarResultado();

        $display("[TB] rejections");
        iniciarRodada(5'b00100);
        applyStimulus(2, 0, 0);
        applyStimulus(1, 2, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(6, 1, 0);
        applyStimulus(3, 7, 0);
        fecharRodada();
        tick();
        applyStimulus(1, 0, 0);
        esperarResultado();

        $display("[TB] timeout with a single vote");
        iniciarRodada(5'b00000);
        applyStimulus(0, 1, 0);
        fecharRodada();
        esperarResultado();

        $display("[TB] last vote together with fechar");
        iniciarRodada(5'b11000);
        applyStimulus(0, 2, 0);
        applyStimulus(1, 2, 0);
        applyStimulus(2, 0, 1);
        esperarResultado();

        $display("[TB] randomized rounds");
        for (int r = 0; r < 25; r++) begin
            int n;
            iniciarRodada(5'($urandom_range(0, 30)));
            n = $urandom_range(1, 12);
            for (int j = 0; j < n && emColeta; j++) begin
                if ($urandom_range(0, 3) == 0) tick();
                applyStimulus($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 9) == 0);
            end
            if (emColeta) fecharRodada();
            esperarResultado();
        end

        tick();
        tick();
        checkOutput("votos_pendentes", filaVotos.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/apuracao_votos.md
Name: apuracao_votos

Overview:
- Day-phase vote tally stage for the PoliLobinho game. Sits between player input and the main datapath.
- Collects one vote per living player, rejects invalid votes, then scans the tallies sequentially to pick the eliminated player.
- Its result drives the datapath's vote-select and `morra` inputs: `morra = resultado_valido && eliminado != 5`.
- Candidate code 5 means "pular" (skip / nobody).

Parameters:
- N_JOGADORES, 5, number of players; candidate indices are 0..N_JOGADORES-1, plus skip code N_JOGADORES.
- W_ID, 3, width of player/candidate index.
- W_CNT, 3, width of each tally counter (must hold N_JOGADORES).

Ports:
- clock  in  1  system clock, rising edge.
- rst_global_n  in  1  asynchronous active-low reset.
- iniciar  in  1  pulse; opens a new voting round.
- fechar  in  1  pulse; forces end of collection (discussion timeout).
- voto_valido  in  1  pulse; one vote presented this cycle.
- jogador_votante  in  W_ID  player casting the vote.
- jogador_escolhido  in  W_ID  candidate voted for (0..4, or 5 = skip).
- mortes  in  N_JOGADORES  dead-player mask; bit i = 1 means player i is dead.
- ocupado  out  1  high in COLETANDO and APURANDO.
- voto_aceito  out  1  one-cycle pulse, registered.
- voto_rejeitado  out  1  one-cycle pulse, registered.
- resultado_valido  out  1  one-cycle pulse.
- eliminado  out  W_ID  winning candidate; 5 = nobody eliminated.
- empate  out  1  tie flag for the last result.

Behaviour:
- Reset (async, rst_global_n = 0):
  - state OCIOSO; all tallies, voted-mask and scan registers cleared.
  - eliminado = 5; all other outputs 0.
- FSM states: OCIOSO, COLETANDO, APURANDO, RESULTADO.
- OCIOSO:
  - iniciar → clear tallies and voted-mask, go to COLETANDO next cycle.
  - eliminado and empate hold their last values.
- COLETANDO, vote acceptance. A vote (voto_valido = 1) is accepted only if all of the following hold:
  - jogador_votante < N_JOGADORES;
  - !mortes[jogador_votante];
  - the voter's voted-mask bit is 0;
  - jogador_escolhido == 5, or (jogador_escolhido < 5 and !mortes[jogador_escolhido]).
- Accepted vote:
  - tally[escolhido] += 1 and the voter's mask bit is set, both at the clock edge;
  - voto_aceito is high the following cycle.
- Any failed condition: no state change; voto_rejeitado is high the following cycle.
- COLETANDO, closing:
  - Close when fechar = 1, or when the registered voted-mask equals ~mortes (all living players have voted).
  - The mask comparison uses registered values, so the round closes the cycle after the last accepted vote.
  - voto_valido and fechar in the same cycle: the vote is processed first, then the round closes.
- COLETANDO, restart: iniciar clears the round and stays in COLETANDO. iniciar is ignored in all other non-OCIOSO states.
- APURANDO (scan), entered at cycle T:
  - Index i steps 0..5, one candidate per cycle, during cycles T..T+5.
  - tally[i] > max: max ← tally[i], arg ← i, tie ← 0.
  - tally[i] == max and max > 0: tie ← 1.
  - Votes arriving during APURANDO are rejected.
- RESULTADO, at cycle T+6:
  - resultado_valido = 1 for exactly one cycle.
  - eliminado = arg, except eliminado = 5 when tie = 1 or max = 0.
  - empate = tie.
  - Return to OCIOSO.
  - Skip (5) can win outright; eliminado = 5, empate = 0.
- Timing: latency from the closing event to resultado_valido is 7 cycles.
- Width rules:
  - tallies saturate at N_JOGADORES; overflow is impossible given the acceptance rules.
  - mortes is sampled combinationally every cycle; a death mid-round affects later votes only.

Optional Feature:
- Macro: MAIORIA_ABSOLUTA_EN.
- Defined:
  - a non-skip winner is eliminated only if max*2 > number of living players, with the living count taken from mortes at scan start;
  - otherwise eliminado = 5, empate = 0.
- Undefined: simple plurality as described above.

Decomposition:
- Shared package `lobinho_pkg` holds:
  - the FSM state encoding;
  - N_JOGADORES;
  - constants PULAR = 3'd5, CLASSE_ALDEAO/LOBO/MEDICO.
- One natural sub-module, `scan_maximo`: sequential argmax/tie tracker with start/step/done interface, instantiated once.

Test Plan:
- Reset, then iniciar; all alive. Players 0,1,2 vote 3, player 3 votes 4, player 4 votes 5 → closes automatically; 7 cycles later resultado_valido = 1, eliminado = 3, empate = 0.
- Tie: mortes = 5'b00001. Players 1,2 vote 3; players 3,4 vote 4 → eliminado = 5, empate = 1.
- Rejections: mortes = 5'b00100. Player 2 votes; player 1 votes for 2; player 0 votes twice → voto_rejeitado pulses each time; tallies unchanged.
- Timeout: one vote (player 0 → 1), then fechar → eliminado = 1 (plurality); with MAIORIA_ABSOLUTA_EN → eliminado = 5.
- Async reset asserted during APURANDO → outputs return immediately to reset values; next iniciar starts a clean round.
- Simultaneous voto_valido (last living voter) and fechar → vote counted and reflected in the result; single resultado_valido pulse.
